// File: rtl/obi_rr_arbiter_pkg.sv
// obi_rr_arbiter_pkg: OBI bus widths, request/response structs and rr helper
package obi_rr_arbiter_pkg;
    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

    typedef struct packed {
        logic [OBI_AW-1:0]  addr;
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DW-1:0] rdata;
    } obi_rsp_t;

    function automatic int next_idx(input int i, input int n);
        return (i + 1 == n) ? 0 : i + 1;
    endfunction
endpackage

// File: rtl/obi_rr_arbiter_if.sv
// obi_rr_arbiter_if: controller-side and secondary-side OBI signals of the arbiter
interface obi_rr_arbiter_if #(parameter int NUM_CTRL = 2);
    import obi_rr_arbiter_pkg::*;
    logic [NUM_CTRL-1:0]         ctrl_req_i;
    logic [NUM_CTRL-1:0]         ctrl_gnt_o;
    logic [NUM_CTRL*OBI_AW-1:0]  ctrl_addr_i;
    logic [NUM_CTRL-1:0]         ctrl_we_i;
    logic [NUM_CTRL*OBI_BEW-1:0] ctrl_be_i;
    logic [NUM_CTRL*OBI_DW-1:0]  ctrl_wdata_i;
    logic [NUM_CTRL-1:0]         ctrl_rvalid_o;
    logic [NUM_CTRL*OBI_DW-1:0]  ctrl_rdata_o;
    logic                        secondary_req_o;
    logic                        secondary_gnt_i;
    logic [OBI_AW-1:0]           secondary_addr_o;
    logic                        secondary_we_o;
    logic [OBI_BEW-1:0]          secondary_be_o;
    logic [OBI_DW-1:0]           secondary_wdata_o;
    logic                        secondary_rvalid_i;
    logic [OBI_DW-1:0]           secondary_rdata_i;
    logic                        err_o;

    modport slave (
        input  ctrl_req_i, ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i,
        input  secondary_gnt_i, secondary_rvalid_i, secondary_rdata_i,
        output ctrl_gnt_o, ctrl_rvalid_o, ctrl_rdata_o,
        output secondary_req_o, secondary_addr_o, secondary_we_o, secondary_be_o, secondary_wdata_o,
        output err_o
    );

    modport master (
        output ctrl_req_i, ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i,
        output secondary_gnt_i, secondary_rvalid_i, secondary_rdata_i,
        input  ctrl_gnt_o, ctrl_rvalid_o, ctrl_rdata_o,
        input  secondary_req_o, secondary_addr_o, secondary_we_o, secondary_be_o, secondary_wdata_o,
        input  err_o
    );
endinterface

// File: rtl/obi_rr_arbiter_id_fifo.sv
// obi_id_fifo: synchronous FIFO of controller ids for outstanding transactions
module obi_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr, r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign empty = r_wptr == r_rptr;
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout  = r_mem[r_rptr[AW-1:0]];

    // pointer update; the extra msb distinguishes full from empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full) r_wptr <= r_wptr + 1'b1;
            if (pop && !empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    // storage needs no reset, occupancy is defined by the pointers
    always_ff @(posedge clk_i) begin
        if (push && !full) r_mem[r_wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI secondary port among NUM_CTRL controllers
module obi_rr_arbiter
    import obi_rr_arbiter_pkg::*;
#(
    parameter int NUM_CTRL        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    obi_rr_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NUM_CTRL);

    logic [IW-1:0]              r_rr_ptr, r_locked_id, w_scan, w_idx, w_sel, w_head;
    logic                       r_lock, r_err, w_req, w_accept, w_pop, w_full, w_empty;
    logic [NUM_CTRL-1:0]        r_rvalid;
    logic [NUM_CTRL*OBI_DW-1:0] r_rdata;
    obi_req_t                   w_reqs [NUM_CTRL];
    obi_req_t                   w_sreq;
    obi_rsp_t                   w_rsp;

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_req
        assign w_reqs[k] = '{addr:  bus.ctrl_addr_i[k*OBI_AW +: OBI_AW],
                             we:    bus.ctrl_we_i[k],
                             be:    bus.ctrl_be_i[k*OBI_BEW +: OBI_BEW],
                             wdata: bus.ctrl_wdata_i[k*OBI_DW +: OBI_DW]};
    end

    // first requester at or after rr_ptr; scanning backwards lets the nearest one win last
    always_comb begin
        w_scan = r_rr_ptr;
        w_idx  = '0;
        for (int i = NUM_CTRL - 1; i >= 0; i--) begin
            w_idx = IW'((int'(r_rr_ptr) + i) % NUM_CTRL);
            if (bus.ctrl_req_i[w_idx]) w_scan = w_idx;
        end
    end

    assign w_sel    = r_lock ? r_locked_id : w_scan;
    assign w_sreq   = w_reqs[w_sel];
    assign w_req    = !rst_i && bus.ctrl_req_i[w_sel] && !w_full;
    assign w_accept = w_req && bus.secondary_gnt_i;
    assign w_pop    = bus.secondary_rvalid_i && !w_empty;
    assign w_rsp    = '{rdata: bus.secondary_rdata_i};

    assign bus.secondary_req_o   = w_req;
    assign bus.secondary_addr_o  = w_sreq.addr;
    assign bus.secondary_we_o    = w_sreq.we;
    assign bus.secondary_be_o    = w_sreq.be;
    assign bus.secondary_wdata_o = w_sreq.wdata;
    assign bus.ctrl_gnt_o        = w_accept ? NUM_CTRL'(1) << w_sel : '0;
    assign bus.ctrl_rvalid_o     = r_rvalid;
    assign bus.ctrl_rdata_o      = r_rdata;
    assign bus.err_o             = r_err;

    obi_id_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // rotate priority on accept; hold the selection while a request waits for grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_locked_id <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= IW'(next_idx(int'(w_sel), NUM_CTRL));
            r_lock   <= 1'b0;
        end else if (w_req) begin
            r_lock      <= 1'b1;
            r_locked_id <= w_sel;
        end
    end

    // route each response to the controller at the FIFO head; orphan responses set err
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_pop ? NUM_CTRL'(1) << w_head : '0;
            if (w_pop) r_rdata[w_head*OBI_DW +: OBI_DW] <= w_rsp.rdata;
            if (bus.secondary_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: scoreboard bench for the round-robin OBI arbiter
module tb_obi_rr_arbiter;
    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] pend[$];
    logic [63:0] exp_vec = '0;
    logic [31:0] a1;
    exp_t        e;

    obi_rr_arbiter_if #(.NUM_CTRL(2)) bus();

    obi_rr_arbiter #(.NUM_CTRL(2), .MAX_OUTSTANDING(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr();
        bus.ctrl_addr_i  = {$urandom, $urandom};
        bus.ctrl_we_i    = 2'($urandom);
        bus.ctrl_be_i    = 8'($urandom);
        bus.ctrl_wdata_i = {$urandom, $urandom};
    endtask

    // secondary model: optionally return the oldest pending read data
    task automatic step(input logic [1:0] req, input logic gnt, input bit take);
        bus.ctrl_req_i      = req;
        bus.secondary_gnt_i = gnt;
        if (take && pend.size() > 0) begin
            bus.secondary_rvalid_i = 1'b1;
            bus.secondary_rdata_i  = pend.pop_front();
        end else begin
            bus.secondary_rvalid_i = 1'b0;
            bus.secondary_rdata_i  = $urandom;
        end
        #1;
    endtask

    // p < 0 means no grant expected this cycle
    task automatic expect_grant(input string tag, input int p);
        logic [31:0] d;
        if (p < 0) begin
            chk({tag, "_gnt"}, bus.ctrl_gnt_o, 0);
        end else begin
            chk({tag, "_gnt"}, bus.ctrl_gnt_o, 2'b01 << p);
            chk({tag, "_mux"},
                {bus.secondary_req_o, bus.secondary_addr_o, bus.secondary_we_o, bus.secondary_be_o, bus.secondary_wdata_o},
                {1'b1, bus.ctrl_addr_i[p*32 +: 32], bus.ctrl_we_i[p], bus.ctrl_be_i[p*4 +: 4], bus.ctrl_wdata_i[p*32 +: 32]});
            d = bus.ctrl_addr_i[p*32 +: 32] ^ 32'hC0DE_0000;
            pend.push_back(d);
            exp_q.push_back('{p, d});
        end
    endtask

    always @(negedge clk) begin
        if (bus.ctrl_rvalid_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexp_rvalid", bus.ctrl_rvalid_o, 0);
            end else begin
                e = exp_q.pop_front();
                exp_vec[e.port*32 +: 32] = e.data;
                chk("rv_port", bus.ctrl_rvalid_o, 2'b01 << e.port);
                chk("rdata", bus.ctrl_rdata_o, exp_vec);
            end
        end
    end

    initial begin
        set_addr();
        step(2'b11, 1'b1, 1'b0);
        bus.secondary_rvalid_i = 1'b1;
        tick();
        chk("rst_req", bus.secondary_req_o, 0);
        chk("rst_gnt", bus.ctrl_gnt_o, 0);
        tick();
        chk("rst_rvalid", bus.ctrl_rvalid_o, 0);
        chk("rst_rdata", bus.ctrl_rdata_o, 0);
        chk("rst_err", bus.err_o, 0);
        step(2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // alternating grants with one-cycle echoed responses
        for (int i = 0; i < 4; i++) begin
            set_addr();
            step(2'b11, 1'b1, 1'b1);
            expect_grant("t1_alt", i % 2);
            tick();
        end
        step(2'b00, 1'b0, 1'b1);
        tick();
        step(2'b00, 1'b0, 1'b0);
        tick();
        tick();

        // lock holds ctrl1 while ctrl0 joins and changes its address
        set_addr();
        a1 = bus.ctrl_addr_i[63:32];
        for (int i = 0; i < 3; i++) begin
            if (i > 0) bus.ctrl_addr_i[31:0] = $urandom;
            step(i == 0 ? 2'b10 : 2'b11, 1'b0, 1'b0);
            chk("t2_req", bus.secondary_req_o, 1);
            chk("t2_addr", bus.secondary_addr_o, a1);
            expect_grant("t2_wait", -1);
            tick();
        end
        step(2'b11, 1'b1, 1'b0);
        expect_grant("t2_lock", 1);
        tick();
        set_addr();
        step(2'b11, 1'b1, 1'b1);
        expect_grant("t2_next", 0);
        tick();
        step(2'b00, 1'b0, 1'b1);
        tick();
        step(2'b00, 1'b0, 1'b0);
        tick();
        tick();

        // fill the ID FIFO with a single requester, then free one slot
        for (int i = 0; i < 4; i++) begin
            set_addr();
            step(2'b01, 1'b1, 1'b0);
            expect_grant("t3_fill", 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b1, i == 2);
            chk("t3_full_req", bus.secondary_req_o, 0);
            expect_grant("t3_full", -1);
            tick();
        end
        set_addr();
        step(2'b01, 1'b1, 1'b0);
        expect_grant("t3_one", 0);
        tick();
        step(2'b01, 1'b1, 1'b0);
        chk("t3_refull_req", bus.secondary_req_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0, 1'b1);
            tick();
        end
        step(2'b00, 1'b0, 1'b0);
        tick();
        tick();

        // push and pop together at occupancy 2 must leave room for exactly two more
        for (int i = 0; i < 5; i++) begin
            set_addr();
            step(2'b11, 1'b1, i == 2);
            expect_grant("t4_pp", (i % 2 == 0) ? 1 : 0);
            tick();
        end
        step(2'b11, 1'b1, 1'b0);
        chk("t4_full_req", bus.secondary_req_o, 0);
        expect_grant("t4_full", -1);
        tick();
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0, 1'b1);
            tick();
        end
        step(2'b00, 1'b0, 1'b0);
        tick();
        tick();
        chk("t4_drained", exp_q.size(), 0);

        // response with nothing outstanding
        chk("t5_err_pre", bus.err_o, 0);
        bus.secondary_rvalid_i = 1'b1;
        bus.secondary_rdata_i  = 32'hDEAD_BEEF;
        tick();
        bus.secondary_rvalid_i = 1'b0;
        #1;
        chk("t5_err", bus.err_o, 1);
        chk("t5_no_rvalid", bus.ctrl_rvalid_o, 0);
        tick();
        tick();
        tick();
        chk("t5_err_sticky", bus.err_o, 1);

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            set_addr();
            step(2'b01, 1'b1, 1'b0);
            expect_grant("t6_issue", 0);
            tick();
        end
        rst = 1'b1;
        step(2'b11, 1'b1, 1'b0);
        chk("t6_rst_req", bus.secondary_req_o, 0);
        chk("t6_rst_gnt", bus.ctrl_gnt_o, 0);
        tick();
        step(2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        pend.delete();
        exp_q.delete();
        exp_vec = '0;
        chk("t6_rvalid", bus.ctrl_rvalid_o, 0);
        chk("t6_rdata", bus.ctrl_rdata_o, 0);
        chk("t6_err_clr", bus.err_o, 0);
        bus.secondary_rvalid_i = 1'b1;
        tick();
        bus.secondary_rvalid_i = 1'b0;
        #1;
        chk("t6_err_late", bus.err_o, 1);
        chk("t6_no_rvalid", bus.ctrl_rvalid_o, 0);
        tick();
        tick();
        chk("end_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
